// File: rtl/agc_cdu_driver.sv
//------------------------------------------------------------------------------
// agc_cdu_driver
//
// Computer-side initiator for the CDU command/pulse interface. It accepts one
// command at a time, then drives the CDU discretes (AGCCA, AGCEEC, AGCZ). It
// also drives rate-limited error-counter pulse trains on AFpPCH/AFmPCH. The
// CDU's returned +/- pulse stream (ATpPGH/ATmPGH) is integrated into a 15-bit
// angle counter.
//
// Optional feature macro: AGC_CDU_CLAMP_EN
//   When this macro is defined, a pulse magnitude above MAX_PULSES is issued as
//   MAX_PULSES, and the clamped output reports it. When it is undefined, the
//   full magnitude is issued and clamped is tied 0.
//
// Ports:
//   CLOCKH     sole clock
//   rst        synchronous active-high reset (also forces outputs low at once)
//   cmd_valid  command offered
//   cmd_ready  driver idle and able to accept
//   cmd_op     00 DRIVE, 01 COARSE, 10 ZERO, 11 NOP
//   cmd_count  signed two's-complement pulse count
//   AFpPCH     plus error-counter pulse
//   AFmPCH     minus error-counter pulse
//   AGCCA      coarse-align discrete
//   AGCEEC     error-counter-enable discrete
//   AGCZ       CDU zero discrete
//   ATpPGH     asynchronous plus pulse from CDU
//   ATmPGH     asynchronous minus pulse from CDU
//   angle      accumulated CDU angle, LSB = 360/32768 deg
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse on return to idle
//   clamped    last command was clamped (optional feature only)
//------------------------------------------------------------------------------
module agc_cdu_driver #(
  parameter int PULSE_PERIOD = 4,
  parameter int PULSE_WIDTH  = 1,
  parameter int SETUP_CYC    = 8,
  parameter int ZERO_CYC     = 16,
  parameter int MAX_PULSES   = 192
) (
  input  logic        CLOCKH,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [14:0] cmd_count,
  output logic        AFpPCH,
  output logic        AFmPCH,
  output logic        AGCCA,
  output logic        AGCEEC,
  output logic        AGCZ,
  input  logic        ATpPGH,
  input  logic        ATmPGH,
  output logic [14:0] angle,
  output logic        busy,
  output logic        done,
  output logic        clamped
);

  localparam logic [1:0] OP_DRIVE  = 2'b00;
  localparam logic [1:0] OP_COARSE = 2'b01;
  localparam logic [1:0] OP_ZERO   = 2'b10;

  // Every timed state loads (length - 1) and leaves when the counter hits 0.
  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] ZERO_LOAD  = 16'(ZERO_CYC - 1);
  localparam logic [15:0] HI_LOAD    = 16'(PULSE_WIDTH - 1);
  localparam logic [15:0] LO_LOAD    = 16'(PULSE_PERIOD - PULSE_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO,
    HOLD,
    ZERO
  } state_t;

  state_t      state;
  logic [15:0] cnt_reg;
  logic [14:0] mag_reg;      // pulses still to be started
  logic        neg_reg;
  logic        afp_reg;
  logic        afm_reg;
  logic        agcca_reg;
  logic        agceec_reg;
  logic        agcz_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [14:0] angle_reg;

  logic        accept;
  logic [14:0] cmd_mag;
  logic [14:0] issue_mag;
  logic        is_drive;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign is_drive  = (cmd_op == OP_DRIVE) || (cmd_op == OP_COARSE);

  // |count|; the most negative value -16384 maps to 16384, which still fits.
  assign cmd_mag = cmd_count[14] ? (~cmd_count + 15'd1) : cmd_count;

`ifdef AGC_CDU_CLAMP_EN
  localparam logic [14:0] MAX_MAG = 15'(MAX_PULSES);
  logic clamped_reg;

  assign issue_mag = (cmd_mag > MAX_MAG) ? MAX_MAG : cmd_mag;

  // Clamped reflects only the most recently accepted command.
  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      clamped_reg <= 1'b0;
    end else if (accept) begin
      clamped_reg <= is_drive && (cmd_mag > MAX_MAG);
    end
  end

  assign clamped = clamped_reg && !rst;
`else
  assign issue_mag = cmd_mag;
  assign clamped   = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // Command FSM
  //----------------------------------------------------------------------------
  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      state      <= IDLE;
      cnt_reg    <= '0;
      mag_reg    <= '0;
      neg_reg    <= 1'b0;
      afp_reg    <= 1'b0;
      afm_reg    <= 1'b0;
      agcca_reg  <= 1'b0;
      agceec_reg <= 1'b0;
      agcz_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy_reg <= 1'b1;
            if (is_drive) begin
              state      <= SETUP;
              cnt_reg    <= SETUP_LOAD;
              agceec_reg <= 1'b1;
              agcca_reg  <= (cmd_op == OP_COARSE);
              neg_reg    <= cmd_count[14];
              mag_reg    <= issue_mag;
            end else if (cmd_op == OP_ZERO) begin
              state    <= ZERO;
              cnt_reg  <= ZERO_LOAD;
              agcz_reg <= 1'b1;
            end else begin
              // NOP: a single busy cycle through HOLD with no discretes set.
              state   <= HOLD;
              cnt_reg <= '0;
            end
          end
        end

        SETUP: begin
          if (cnt_reg == '0) begin
            if (mag_reg == '0) begin
              state   <= HOLD;
              cnt_reg <= SETUP_LOAD;
            end else begin
              state   <= PULSE_HI;
              cnt_reg <= HI_LOAD;
              mag_reg <= mag_reg - 15'd1;
              afp_reg <= !neg_reg;
              afm_reg <= neg_reg;
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        PULSE_HI: begin
          if (cnt_reg == '0) begin
            state   <= PULSE_LO;
            cnt_reg <= LO_LOAD;
            afp_reg <= 1'b0;
            afm_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        PULSE_LO: begin
          // The low part of the last pulse period completes before HOLD.
          if (cnt_reg == '0) begin
            if (mag_reg == '0) begin
              state   <= HOLD;
              cnt_reg <= SETUP_LOAD;
            end else begin
              state   <= PULSE_HI;
              cnt_reg <= HI_LOAD;
              mag_reg <= mag_reg - 15'd1;
              afp_reg <= !neg_reg;
              afm_reg <= neg_reg;
            end
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        HOLD: begin
          if (cnt_reg == '0) begin
            state      <= IDLE;
            agceec_reg <= 1'b0;
            agcca_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        ZERO: begin
          if (cnt_reg == '0) begin
            state    <= IDLE;
            agcz_reg <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Return path: 2-flop synchronizers, rising-edge detect, up/down counter.
  //----------------------------------------------------------------------------
  logic [1:0] p_sync;
  logic [1:0] m_sync;
  logic       p_prev;
  logic       m_prev;
  logic       p_rise;
  logic       m_rise;
  logic       zero_hold;

  assign p_rise = p_sync[1] && !p_prev;
  assign m_rise = m_sync[1] && !m_prev;

  // The zero window covers the accept cycle as well, so angle reads 0 on
  // every cycle in which AGCZ is high.
  assign zero_hold = (state == ZERO) || (accept && (cmd_op == OP_ZERO));

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      p_sync    <= '0;
      m_sync    <= '0;
      p_prev    <= 1'b0;
      m_prev    <= 1'b0;
      angle_reg <= '0;
    end else begin
      p_sync <= {p_sync[0], ATpPGH};
      m_sync <= {m_sync[0], ATmPGH};
      p_prev <= p_sync[1];
      m_prev <= m_sync[1];
      if (zero_hold) begin
        angle_reg <= '0;
      end else if (p_rise && !m_rise) begin
        angle_reg <= angle_reg + 15'd1;
      end else if (m_rise && !p_rise) begin
        angle_reg <= angle_reg - 15'd1;
      end
    end
  end

  // Reset aborts in the same cycle: outputs are masked while rst is high.
  assign AFpPCH = afp_reg && !rst;
  assign AFmPCH = afm_reg && !rst;
  assign AGCCA  = agcca_reg && !rst;
  assign AGCEEC = agceec_reg && !rst;
  assign AGCZ   = agcz_reg && !rst;
  assign busy   = busy_reg && !rst;
  assign done   = done_reg && !rst;
  assign angle  = rst ? 15'd0 : angle_reg;

endmodule
